// File: rtl/alarm_bank.sv
`default_nettype none
// ============================================================================
// Module   : alarm_bank
// Purpose  : Multi-slot HH:MM alarm with per-slot arm, timed ringing and
//            snooze with a repeat limit, compared against live BCD clock digits.
// Revision : 1.0  initial release
// ============================================================================
module alarm_bank #(
  parameter int N_ALARMS    = 4,
  parameter int IDX_W       = 2,
  parameter int RING_CYCLES = 60,
  parameter int SNOOZE_MIN  = 5,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          curMin0,
  input  logic [3:0]          curMin1,
  input  logic [3:0]          curHour0,
  input  logic [3:0]          curHour1,
  input  logic                set,
  input  logic                clr,
  input  logic [IDX_W-1:0]    set_idx,
  input  logic                snooze,
  input  logic                dismiss,
  output logic                alarm,
  output logic [N_ALARMS-1:0] ring_vec,
  output logic [N_ALARMS-1:0] armed_vec
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RING   = 2'd1,
    S_SNOOZE = 2'd2
  } state_t;

  localparam logic [7:0] c_ring_last = 8'(RING_CYCLES - 1);
  localparam logic [3:0] c_snz_min   = 4'(SNOOZE_MIN);
  localparam logic [2:0] c_max_snz   = 3'(MAX_SNOOZE);

  logic [15:0]         w_cur_time;
  logic [15:0]         r_prev_time;
  logic                w_min_tick;
  logic [N_ALARMS-1:0] w_ring_nx;
  logic                r_alarm;

  assign w_cur_time = {curHour1, curHour0, curMin1, curMin0};
  // Any change of the displayed time counts as a minute tick.
  assign w_min_tick = (w_cur_time != r_prev_time);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_time <= 16'h0000;
      r_alarm     <= 1'b0;
    end else begin
      r_prev_time <= w_cur_time;
      r_alarm     <= |w_ring_nx;
    end
  end

  assign alarm = r_alarm;

  generate
    for (genvar gi = 0; gi < N_ALARMS; gi++) begin : g_slot
      state_t      r_state, w_state_nx;
      logic [15:0] r_time, w_time_nx;
      logic        r_armed, w_armed_nx;
      logic        r_ring;
      logic [7:0]  r_ring_cnt, w_ring_cnt_nx;
      logic [2:0]  r_snz_used, w_snz_used_nx;
      logic [3:0]  r_snz_cnt, w_snz_cnt_nx;
      logic        w_sel;

      assign w_sel         = (set_idx == IDX_W'(gi));
      assign w_ring_nx[gi] = (w_state_nx == S_RING);
      assign ring_vec[gi]  = r_ring;
      assign armed_vec[gi] = r_armed;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_state    <= S_IDLE;
          r_time     <= 16'h0000;
          r_armed    <= 1'b0;
          r_ring     <= 1'b0;
          r_ring_cnt <= 8'd0;
          r_snz_used <= 3'd0;
          r_snz_cnt  <= 4'd0;
        end else begin
          r_state    <= w_state_nx;
          r_time     <= w_time_nx;
          r_armed    <= w_armed_nx;
          r_ring     <= w_ring_nx[gi];
          r_ring_cnt <= w_ring_cnt_nx;
          r_snz_used <= w_snz_used_nx;
          r_snz_cnt  <= w_snz_cnt_nx;
        end
      end

      always_comb begin
        w_state_nx    = r_state;
        w_time_nx     = r_time;
        w_armed_nx    = r_armed;
        w_ring_cnt_nx = r_ring_cnt;
        w_snz_used_nx = r_snz_used;
        w_snz_cnt_nx  = r_snz_cnt;
        if (set && w_sel) begin
          w_time_nx  = w_cur_time;
          w_armed_nx = 1'b1;
          w_state_nx = S_IDLE;
        end else if (clr && w_sel) begin
          w_armed_nx = 1'b0;
          w_state_nx = S_IDLE;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (!dismiss && w_min_tick && r_armed && (r_time == w_cur_time)) begin
                w_state_nx    = S_RING;
                w_ring_cnt_nx = 8'd0;
                w_snz_used_nx = 3'd0;
              end
            end
            S_RING: begin
              if (dismiss) begin
                w_state_nx = S_IDLE;
              end else if (snooze) begin
                // Exhausted snooze budget turns a snooze press into a dismiss.
                if (r_snz_used == c_max_snz) begin
                  w_state_nx = S_IDLE;
                end else begin
                  w_state_nx    = S_SNOOZE;
                  w_snz_used_nx = r_snz_used + 3'd1;
                  w_snz_cnt_nx  = c_snz_min;
                end
              end else if (r_ring_cnt == c_ring_last) begin
                w_state_nx = S_IDLE;
              end else begin
                w_ring_cnt_nx = r_ring_cnt + 8'd1;
              end
            end
            S_SNOOZE: begin
              if (dismiss) begin
                w_state_nx = S_IDLE;
              end else if (w_min_tick) begin
                if (r_snz_cnt == 4'd1) begin
                  w_state_nx    = S_RING;
                  w_ring_cnt_nx = 8'd0;
                end else begin
                  w_snz_cnt_nx = r_snz_cnt - 4'd1;
                end
              end
            end
            default: w_state_nx = S_IDLE;
          endcase
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire
